// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: FSM state encoding
// and address-map constants.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      BAD  = 2'd3
   } mem_state_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
   localparam int          BYTES_PER_WORD    = 4;

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// Request/response bus between the multi-cycle core and the data-memory responder.
interface mips_data_mem_responder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;
   logic [1:0]            mem_state;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_state
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_state
   );

endinterface

// File: rtl/mips_word_ram.sv
// Single-port word RAM with write-enable and a registered (read-first) output.
module mips_word_ram #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Load/store responder for the MIPS .data segment: one request at a time,
// fixed wait states, then a one-cycle response with read data and error flag.
module mips_data_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DEPTH       = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
   parameter int                    WAIT_CYCLES = 2
) (
   input logic                      clk,
   input logic                      reset,
   mips_data_mem_responder_if.slave bus
);

   localparam int                    IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(DEPTH * BYTES_PER_WORD);
   localparam logic [3:0]            WAIT_INIT = 4'(WAIT_CYCLES);

   mem_state_t            state_reg;
   logic [3:0]            cnt_reg;
   logic                  we_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic                  resp_valid_reg;
   logic                  resp_err_reg;
   logic                  resp_load_reg;

   logic                  accept;
   logic                  commit;
   logic                  cur_we;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic [ADDR_WIDTH-1:0] offset;
   logic                  legal;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign accept = bus.req_valid && (state_reg == IDLE) && !reset;

   // With zero wait states the commit edge is the accept edge itself, so the
   // decode must look at the live bus rather than the not-yet-latched copy.
   assign commit = ((WAIT_CYCLES == 0) && accept) ||
                   ((state_reg == WAIT) && (cnt_reg == 4'd1));

   assign cur_we    = (state_reg == IDLE) ? bus.req_we    : we_reg;
   assign cur_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
   assign cur_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;

   // Wrap-around subtraction makes addresses below the base look huge, hence illegal.
   assign offset = cur_addr - BASE_ADDR;
   assign legal  = (cur_addr[1:0] == 2'b00) && (offset < SPAN);
   assign ram_we = commit && cur_we && legal && !reset;

   mips_word_ram #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (offset[IDX_W+1:2]),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= 4'd0;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         resp_load_reg  <= 1'b0;
      end else begin
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         resp_load_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  we_reg    <= bus.req_we;
                  addr_reg  <= bus.req_addr;
                  wdata_reg <= bus.req_wdata;
                  cnt_reg   <= WAIT_INIT;
                  state_reg <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) begin
                  state_reg <= RESP;
               end
            end
            RESP:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
         if (commit) begin
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= !legal;
            resp_load_reg  <= !cur_we && legal;
         end
      end
   end

   // The RAM output register is loaded on the commit edge; gating keeps it
   // zero for stores, errors and every cycle outside RESP.
   assign bus.resp_rdata = resp_load_reg ? ram_rdata : '0;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_err   = resp_err_reg;
   assign bus.req_ready  = (state_reg == IDLE);
   assign bus.mem_state  = state_reg;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed bench for mips_data_mem_responder with WAIT_CYCLES = 2, DEPTH = 64.
module tb_mips_data_mem_responder;

   localparam int W = 2;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mips_data_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   mips_data_mem_responder #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .DEPTH       (64),
      .BASE_ADDR   (32'h1001_0000),
      .WAIT_CYCLES (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction: accept, W wait cycles, one-cycle response, back to IDLE.
   task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rdata, input logic hold,
                         input logic [31:0] alt_addr);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      chk({tag, ".ready_pre"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         bus.req_addr = alt_addr;
      end else begin
         bus.req_valid = 1'b0;
      end
      chk({tag, ".ready_wait"}, 32'(bus.req_ready), 32'd0);
      chk({tag, ".valid_wait"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, ".state_wait"}, 32'(bus.mem_state), 32'd1);
      repeat (W - 1) begin
         @(negedge clk);
         chk({tag, ".valid_early"}, 32'(bus.resp_valid), 32'd0);
      end
      @(negedge clk);
      chk({tag, ".valid_resp"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, ".err"}, 32'(bus.resp_err), 32'(exp_err));
      chk({tag, ".rdata"}, bus.resp_rdata, exp_rdata);
      chk({tag, ".state_resp"}, 32'(bus.mem_state), 32'd2);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".state_post"}, 32'(bus.mem_state), 32'd0);
      chk({tag, ".valid_post"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, ".rdata_post"}, bus.resp_rdata, 32'd0);
      chk({tag, ".err_post"}, 32'(bus.resp_err), 32'd0);
      chk({tag, ".ready_post"}, 32'(bus.req_ready), 32'd1);
      $display("txn %s we=%0d addr=%h wdata=%h exp_err=%0d exp_rdata=%h",
               tag, we, addr, wdata, exp_err, exp_rdata);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'd0;
      bus.req_wdata = 32'd0;
      reset = 1'b1;
      #1;
      chk("rst.ready", 32'(bus.req_ready), 32'd1);
      chk("rst.valid", 32'(bus.resp_valid), 32'd0);
      chk("rst.rdata", bus.resp_rdata, 32'd0);
      chk("rst.err", 32'(bus.resp_err), 32'd0);
      chk("rst.state", 32'(bus.mem_state), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // 1: store then load back
      do_req("t1_sw", 1'b1, 32'h1001_0000, 32'h0000_002C, 1'b0, 32'h0, 1'b0, 32'h0);
      do_req("t1_lw", 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h0000_002C, 1'b0, 32'h0);
      // 2: neighbouring word, no aliasing
      do_req("t2_sw", 1'b1, 32'h1001_0004, 32'h0000_0014, 1'b0, 32'h0, 1'b0, 32'h0);
      do_req("t2_lw4", 1'b0, 32'h1001_0004, 32'h0, 1'b0, 32'h0000_0014, 1'b0, 32'h0);
      do_req("t2_lw0", 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h0000_002C, 1'b0, 32'h0);
      // 3: misaligned store is rejected and writes nothing
      do_req("t3_sw", 1'b1, 32'h1001_0002, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 32'h0);
      do_req("t3_lw", 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h0000_002C, 1'b0, 32'h0);
      // 4: range boundaries
      do_req("t4_hi", 1'b0, 32'h1001_0100, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
      do_req("t4_lo", 1'b0, 32'h1000_FFFC, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
      do_req("t4_top", 1'b1, 32'h1001_00FC, 32'h0000_0777, 1'b0, 32'h0, 1'b0, 32'h0);
      do_req("t4_toplw", 1'b0, 32'h1001_00FC, 32'h0, 1'b0, 32'h0000_0777, 1'b0, 32'h0);
      // 5: req_valid held through WAIT with a new address; original is served
      do_req("t5_hold", 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h0000_002C, 1'b1, 32'h1001_0004);
      @(negedge clk);
      chk("t5.no_second_resp", 32'(bus.resp_valid), 32'd0);
      chk("t5.idle", 32'(bus.mem_state), 32'd0);

      // 6: completed store survives; store aborted by reset in WAIT does not land
      do_req("t6_sw", 1'b1, 32'h1001_0008, 32'h0000_0011, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h1001_0008;
      bus.req_wdata = 32'h0000_0099;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("t6.state_wait", 32'(bus.mem_state), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t6.rst_state", 32'(bus.mem_state), 32'd0);
      chk("t6.rst_ready", 32'(bus.req_ready), 32'd1);
      chk("t6.rst_valid", 32'(bus.resp_valid), 32'd0);
      chk("t6.rst_rdata", bus.resp_rdata, 32'd0);
      chk("t6.rst_err", 32'(bus.resp_err), 32'd0);
      $display("txn t6_abort we=1 addr=10010008 wdata=00000099 reset during WAIT");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      do_req("t6_lw", 1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'h0000_0011, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
